bcd_seq_ctrl: RTL and testbench

//   Sequential binary-to-BCD conversion controller using the shift/add-3 (double-dabble) method.

---
 rtl/bcd_seq_ctrl.sv | 96 +++++++++
 tb/tb_bcd_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift/add-3). One operand is accepted on a
// start/ready handshake, W shift steps follow, then the packed BCD result and an
// overflow flag are latched together with a one-cycle done pulse.
module bcd_seq_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned ND = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd,
  output logic            overflow
);

  localparam int unsigned SW = 4 * ND;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    opnd_q;
  logic [SW-1:0]   scratch_q;
  logic            ovf_q;
  logic [CW-1:0]   cnt_q;

  logic [SW-1:0]   adj;
  logic [SW:0]     shifted;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the operand MSB.
  // The bit leaving the top nibble is the overflow carry.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(ND); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
    shifted = {adj, opnd_q[W-1]};
  end

  // Control FSM, datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      opnd_q    <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            opnd_q    <= bin;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CW'(W - 1);
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= shifted[SW-1:0];
          opnd_q    <= opnd_q << 1;
          if (shifted[SW]) begin
            ovf_q <= 1'b1;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd      <= scratch_q;
          overflow <= ovf_q;
          done     <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake status comes from the state register alone, never from start.
  assign ready = (state_q == StIdle);
  assign busy  = ~ready;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: a 3-digit instance and a 2-digit instance
// (the latter exercises overflow) share clock and reset.
module tb_bcd_seq_ctrl;

  logic        clk;
  logic        clr;
  logic        start, start2;
  logic [7:0]  bin, bin2;
  logic        ready, busy, done, overflow;
  logic        ready2, busy2, done2, ovf2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_err = 0;

  bcd_seq_ctrl #(.W(8), .ND(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .bin      (bin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  bcd_seq_ctrl #(.W(8), .ND(2)) dut2 (
    .clk      (clk),
    .clr      (clr),
    .start    (start2),
    .bin      (bin2),
    .ready    (ready2),
    .busy     (busy2),
    .done     (done2),
    .bcd      (bcd2),
    .overflow (ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated conversion on either instance; checks latency, result and pulse width.
  task automatic conv(input bit sel, input logic [7:0] val, input logic [11:0] exp_bcd,
                      input logic exp_ovf);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    chk("ready_before", {31'b0, sel ? ready2 : ready}, 32'd1);
    if (sel) begin
      start2 = 1'b1;
      bin2   = val;
    end else begin
      start  = 1'b1;
      bin    = val;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
    bin    = ~val;
    bin2   = ~val;
    chk("busy_after_accept", {31'b0, sel ? busy2 : busy}, 32'd1);
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = sel ? done2 : done;
    end
    chk("latency", n, 32'd9);
    chk("bcd", sel ? {24'b0, bcd2} : {20'b0, bcd}, {20'b0, exp_bcd});
    chk("overflow", {31'b0, sel ? ovf2 : overflow}, {31'b0, exp_ovf});
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, sel ? done2 : done}, 32'd0);
  endtask

  initial begin
    int          n;
    int          dones;
    int          done_at;
    logic        ready_leak;
    logic [7:0]  ops [4];
    logic [11:0] exps[4];

    clk    = 1'b0;
    clr    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    bin    = 8'd0;
    bin2   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    // T1: reset state, then 255
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_bcd", {20'b0, bcd}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    conv(1'b0, 8'd255, 12'h255, 1'b0);

    // T2: digit boundaries
    conv(1'b0, 8'd0,   12'h000, 1'b0);
    conv(1'b0, 8'd99,  12'h099, 1'b0);
    conv(1'b0, 8'd100, 12'h100, 1'b0);

    // T3: start held high, operands alternate 37/200
    ops[0] = 8'd37;  ops[1] = 8'd200; ops[2] = 8'd37;  ops[3] = 8'd200;
    exps[0] = 12'h037; exps[1] = 12'h200; exps[2] = 12'h037; exps[3] = 12'h200;
    start = 1'b1;
    bin   = ops[0];
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bin        = (k < 3) ? ops[k+1] : 8'd0;
      n          = 0;
      ready_leak = 1'b0;
      while (!done && n < 20) begin
        if (ready) ready_leak = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      if (k == 3) start = 1'b0;
      chk("b2b_period", n, 32'd9);
      chk("b2b_ready_low", {31'b0, ready_leak}, 32'd0);
      chk("b2b_bcd", {20'b0, bcd}, {20'b0, exps[k]});
      chk("b2b_ready_at_done", {31'b0, ready}, 32'd1);
    end
    @(posedge clk); #1;

    // T4: start pulses while busy are ignored
    start   = 1'b1;
    bin     = 8'd123;
    @(posedge clk); #1;
    start   = 1'b0;
    bin     = 8'd99;
    dones   = 0;
    done_at = 0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        done_at = n;
      end
      start = (n == 1) || (n == 8);
    end
    start = 1'b0;
    chk("busy_start_dones", dones, 32'd1);
    chk("busy_start_done_at", done_at, 32'd9);
    chk("busy_start_bcd", {20'b0, bcd}, 32'h123);
    chk("busy_start_idle", {31'b0, ready}, 32'd1);

    // T5: clr during SHIFT aborts the conversion
    start = 1'b1;
    bin   = 8'd255;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_bcd", {20'b0, bcd}, 32'd0);
    chk("abort_ovf", {31'b0, overflow}, 32'd0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    conv(1'b0, 8'd42, 12'h042, 1'b0);

    // T6: two-digit instance, overflow and its clearing
    conv(1'b1, 8'd123, 12'h023, 1'b1);
    conv(1'b1, 8'd45,  12'h045, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
